// File: rtl/uart_rx_stage.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_stage
// Brief    : Oversampling UART receive front-end. Synchronizes i_rx, deframes
//            8N1 characters (8E1/8O1 when UART_RX_PARITY_EN is defined) and
//            holds each byte in a one-entry register with a valid/ack
//            handshake. Reports framing, overrun and parity errors as
//            one-cycle pulses.
// Options  : `define UART_RX_PARITY_EN builds the PARITY state.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_stage #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    input  logic       i_ack,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_parity_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    // Start sample lands H cycles after the edge; counter starts one cycle late.
    localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'((CLKS_PER_BIT - 1) / 2 - 1);
    localparam logic [CNT_W-1:0] c_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    localparam logic c_PAR_ODD = 1'(PARITY_ODD);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    logic             sync_meta_q;
    logic             rx_s_q;
    logic             rx_prev_q;
    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [2:0]       bit_idx_q,   bit_idx_d;
    logic [7:0]       shift_q,     shift_d;
    logic [7:0]       data_q,      data_d;
    logic             valid_q,     valid_d;
    logic             busy_q,      busy_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q,   overrun_d;
    logic             par_bad_q,   par_bad_d;
`ifdef UART_RX_PARITY_EN
    logic             parity_err_q, parity_err_d;
`endif

    // Next-state, datapath and completion/handshake decisions.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        par_bad_d   = par_bad_q;
`ifdef UART_RX_PARITY_EN
        parity_err_d = 1'b0;
`endif

        // Consumer ack drains the holding register; a same-cycle completion overrides below.
        if (valid_q && i_ack) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Only a fresh 1->0 edge starts a frame, so a held break stays idle.
                if (rx_prev_q && !rx_s_q) begin
                    state_d   = START;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    shift_d   = '0;
                    par_bad_d = 1'b0;
                end
            end
            START: begin
                if (cnt_q == c_HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == c_BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == c_BIT_LAST) begin
                    cnt_d     = '0;
                    par_bad_d = ((^shift_q) ^ rx_s_q) != c_PAR_ODD;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == c_BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (!rx_s_q) begin
                        frame_err_d = 1'b1;
                    end else if (par_bad_q) begin
`ifdef UART_RX_PARITY_EN
                        parity_err_d = 1'b1;
`endif
                    end else if (valid_q && !i_ack) begin
                        overrun_d = 1'b1;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // Synchronizer, FSM and registered outputs; reset idles the line high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_meta_q <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            par_bad_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_meta_q <= i_rx;
            rx_s_q      <= sync_meta_q;
            rx_prev_q   <= rx_s_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            par_bad_q   <= par_bad_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_busy      = busy_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = parity_err_q;
`else
    // No parity in the frame: the error can never fire and the parity sense is irrelevant.
    assign o_parity_err = 1'b0 & (PARITY_ODD != 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_stage
// Brief    : Directed self-checking bench for uart_rx_stage (CLKS_PER_BIT=8).
//            Parity vectors are exercised when UART_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_stage;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       ack;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_busy;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_parity_err;

    int n_eval = 0;
    int n_fail = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    int vrise_cnt = 0;
    logic v_prev = 1'b0;

    always #5 clk = ~clk;

    uart_rx_stage #(
        .CLKS_PER_BIT (CPB),
        .PARITY_ODD   (0)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx         (rx),
        .i_ack        (ack),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_busy       (o_busy),
        .o_frame_err  (o_frame_err),
        .o_overrun    (o_overrun),
        .o_parity_err (o_parity_err)
    );

    // Count pulse-cycles and valid rising edges, sampled mid-cycle.
    always @(negedge clk) begin
        if (o_frame_err)  fe_cnt <= fe_cnt + 1;
        if (o_overrun)    ov_cnt <= ov_cnt + 1;
        if (o_parity_err) pe_cnt <= pe_cnt + 1;
        if (o_valid && !v_prev) vrise_cnt <= vrise_cnt + 1;
        v_prev <= o_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        cyc(CPB);
    endtask

    // Full frame; ack_at_stop raises i_ack only for the stop-sample cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input logic par_b, input logic ack_at_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_b);
`endif
        rx = stop_b;
        cyc(5);
        ack = ack_at_stop;
        cyc(1);
        ack = 1'b0;
        cyc(2);
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
    endtask

    initial begin
        logic [7:0] a5;
        a5    = 8'hA5;
        rst_n = 1'b0;
        rx    = 1'b1;
        ack   = 1'b0;
        cyc(3);
        chk("rst_data",  o_data,       32'h00);
        chk("rst_valid", o_valid,      32'h0);
        chk("rst_busy",  o_busy,       32'h0);
        chk("rst_ferr",  o_frame_err,  32'h0);
        chk("rst_ovr",   o_overrun,    32'h0);
        chk("rst_perr",  o_parity_err, 32'h0);
        rst_n = 1'b1;
        cyc(5);

        // 0xA5 with exact completion timing.
        send_bit(1'b0);
        chk("a5_busy", o_busy, 32'h1);
        for (int i = 0; i < 8; i++) send_bit(a5[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(1'b0);
`endif
        rx = 1'b1;
        cyc(5);
        chk("a5_valid_early", o_valid, 32'h0);
        cyc(1);
        chk("a5_valid", o_valid, 32'h1);
        chk("a5_data",  o_data,  32'hA5);
        cyc(2);
        cyc(20);
        chk("a5_valid_hold", o_valid, 32'h1);
        ack_pulse();
        chk("a5_valid_clr", o_valid, 32'h0);
        cyc(10);
        chk("a5_busy_idle", o_busy, 32'h0);

        // Two-cycle glitch on the line.
        rx = 1'b0;
        cyc(2);
        rx = 1'b1;
        cyc(1);
        chk("gl_busy_start", o_busy, 32'h1);
        cyc(3);
        chk("gl_busy_end", o_busy, 32'h0);
        cyc(100);
        chk("gl_valid", o_valid, 32'h0);
        chk("gl_vrise", vrise_cnt, 32'd1);
        chk("gl_ferr",  fe_cnt,    32'd0);

        // Framing error then a held break.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        chk("fe_valid", o_valid, 32'h0);
        cyc(50);
        chk("fe_count", fe_cnt,  32'd1);
        chk("fe_busy",  o_busy,  32'h0);
        chk("fe_vrise", vrise_cnt, 32'd1);
        rx = 1'b1;
        cyc(20);
        chk("fe_idle_busy", o_busy, 32'h0);

        // Back-to-back without ack: overrun, first byte retained.
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        cyc(2);
        chk("ov_data",  o_data,  32'h11);
        chk("ov_valid", o_valid, 32'h1);
        chk("ov_count", ov_cnt,  32'd1);
        ack_pulse();
        chk("ov_clr", o_valid, 32'h0);
        cyc(10);

        // Ack coincides with the second completion: new byte replaces old.
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b1);
        cyc(2);
        chk("sim_data",  o_data,  32'h22);
        chk("sim_valid", o_valid, 32'h1);
        chk("sim_ovr",   ov_cnt,  32'd1);
        ack_pulse();
        cyc(10);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        chk("par_ok_data",  o_data,  32'h07);
        chk("par_ok_valid", o_valid, 32'h1);
        ack_pulse();
        cyc(5);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        cyc(2);
        chk("par_bad_valid", o_valid, 32'h0);
        chk("par_bad_count", pe_cnt,  32'd1);
        chk("par_bad_data",  o_data,  32'h07);
        cyc(5);
`else
        chk("perr_tied", pe_cnt, 32'd0);
`endif

        // Leave a byte pending, then reset in the middle of data bit 4.
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_data", o_data, 32'hFF);
        begin
            logic [7:0] d5a;
            d5a = 8'h5A;
            send_bit(1'b0);
            for (int i = 0; i < 4; i++) send_bit(d5a[i]);
            rx = d5a[4];
            cyc(3);
            #2;
            chk("pre_rst_busy",  o_busy,  32'h1);
            chk("pre_rst_valid", o_valid, 32'h1);
            rst_n = 1'b0;
            #1;
            chk("mid_rst_data",  o_data,  32'h00);
            chk("mid_rst_valid", o_valid, 32'h0);
            chk("mid_rst_busy",  o_busy,  32'h0);
            @(negedge clk);
            rx    = 1'b1;
            rst_n = 1'b1;
            cyc(CPB * 8);
            chk("post_rst_busy", o_busy, 32'h0);
            send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
            chk("post_rst_data",  o_data,  32'h5A);
            chk("post_rst_valid", o_valid, 32'h1);
        end
        cyc(5);
        chk("final_ferr", fe_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
